// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO: occupancy
// width helper and the read-mode enumeration.
package fifo_pkg;

  // Read-mode selector; FIFO_STD registers dout on a pop, FIFO_FWFT shows the head.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Capture accepted writes; no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty watermarks, write-through-when-full on a simultaneous pop,
// overflow/underflow pulses and standard or first-word-fall-through reads.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam fifo_mode_e       MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Flags derive only from the registered count, so they cannot glitch.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // A pop frees a slot in the same cycle, letting a write land even when full.
  assign w_rd_ok = rd_en && !w_empty;
  assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok && !rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Pointer, occupancy and error-pulse state; requests in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en && !w_wr_ok;
      r_underflow <= rd_en && !w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;

      // Registered read data: updates only on an accepted pop, holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_ok) begin
          r_dout <= w_rd_data;
        end
      end

      assign dout = r_dout;
    end else begin : g_fwft
      // Head of queue is presented directly; zero while nothing is stored.
      assign dout = w_empty ? '0 : w_rd_data;
    end
  endgenerate

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read and an FWFT instance share the
// same stimulus; a queue-based model predicts every output each cycle.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [CW-1:0] af_thresh = CW'(12);
  logic [CW-1:0] ae_thresh = CW'(2);

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [CW-1:0] s_count, f_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_ov   = 1'b0;
  logic          exp_un   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ov), .underflow(f_un)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue semantics: a pop needs data, a push needs room or a same-cycle pop.
  task automatic model_step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    if (r) begin
      q.delete();
      exp_dout = '0;
      exp_ov   = 1'b0;
      exp_un   = 1'b0;
    end else begin
      rd_ok  = rd && (q.size() != 0);
      wr_ok  = w && ((q.size() != DEPTH) || rd_ok);
      exp_ov = w && !wr_ok;
      exp_un = rd && !rd_ok;
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("s_count", 32'(s_count), 32'(sz));
    chk("f_count", 32'(f_count), 32'(sz));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("s_full",  32'(s_full),  32'(sz == DEPTH));
    chk("f_full",  32'(f_full),  32'(sz == DEPTH));
    chk("s_af",    32'(s_af),    32'(sz >= int'(af_thresh)));
    chk("f_af",    32'(f_af),    32'(sz >= int'(af_thresh)));
    chk("s_ae",    32'(s_ae),    32'(sz <= int'(ae_thresh)));
    chk("f_ae",    32'(f_ae),    32'(sz <= int'(ae_thresh)));
    chk("s_ovf",   32'(s_ov),    32'(exp_ov));
    chk("f_ovf",   32'(f_ov),    32'(exp_ov));
    chk("s_unf",   32'(s_un),    32'(exp_un));
    chk("f_unf",   32'(f_un),    32'(exp_un));
    chk("s_dout",  32'(s_dout),  32'(exp_dout));
    chk("f_dout",  32'(f_dout),  (sz != 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    model_step(r, w, rd, d);
    #1;
    check_all();
  endtask

  initial begin
    // Reset with watermarks 12 / 2
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_ae",    32'(s_ae),    32'd1);
    chk("rst_af",    32'(s_af),    32'd0);
    chk("rst_dout",  32'(s_dout),  32'd0);

    // Fill 0..15, read 8, write 16..23, read 16 (wraps both pointers)
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, DW'(i));
      if (i == 10) chk("af_before_12", 32'(s_af), 32'd0);
      if (i == 11) chk("af_at_12", 32'(s_af), 32'd1);
    end
    chk("fill_full",  32'(s_full),  32'd1);
    chk("fill_count", 32'(s_count), 32'd16);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("drain8_dout", 32'(s_dout), 32'd7);
    for (int i = 16; i < 24; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      chk("order_dout", 32'(s_dout), 32'(8 + i));
      if (i == 12) chk("ae_at_3", 32'(s_ae), 32'd0);
      if (i == 13) chk("ae_at_2", 32'(s_ae), 32'd1);
    end

    // Overflow while full with no read
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h40 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(s_ov),    32'd1);
    chk("ovf_count", 32'(s_count), 32'd16);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("ovf_clear", 32'(s_ov), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("ovf_last", 32'(s_dout), 32'h4F);

    // Underflow on empty; dout holds
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("unf_pulse", 32'(s_un),   32'd1);
    chk("unf_hold",  32'(s_dout), 32'h4F);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("unf_clear", 32'(s_un), 32'd0);

    // Simultaneous read/write at empty
    cycle(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("sim_empty_unf",   32'(s_un),    32'd1);
    chk("sim_empty_count", 32'(s_count), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("sim_empty_data", 32'(s_dout), 32'hA5);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h60 + i));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, DW'(8'h70 + i));
      chk("sim5_count", 32'(s_count), 32'd5);
      chk("sim5_order", 32'(s_dout),  32'(8'h60 + i));
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous read/write at full: write-through accepted
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h80 + i));
    cycle(1'b0, 1'b1, 1'b1, 8'h3C);
    chk("simfull_ovf",   32'(s_ov),    32'd0);
    chk("simfull_count", 32'(s_count), 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("simfull_last", 32'(s_dout), 32'h3C);

    // FWFT visibility
    cycle(1'b0, 1'b1, 1'b0, 8'h11);
    chk("fwft_show", 32'(f_dout), 32'h11);
    cycle(1'b0, 1'b1, 1'b0, 8'h22);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("fwft_next", 32'(f_dout), 32'h22);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("fwft_zero", 32'(f_dout), 32'h00);

    // Reset mid-operation together with requests
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h90 + i));
    cycle(1'b1, 1'b1, 1'b1, 8'h55);
    chk("rmid_count", 32'(s_count), 32'd0);
    chk("rmid_empty", 32'(s_empty), 32'd1);
    chk("rmid_ovf",   32'(s_ov),    32'd0);
    chk("rmid_unf",   32'(s_un),    32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h77);
    chk("rmid_fwft", 32'(f_dout), 32'h77);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("rmid_std", 32'(s_dout), 32'h77);

    // Randomised traffic with drifting bias, thresholds and rare resets
    for (int n = 0; n < 3000; n++) begin
      int wp;
      int rp;
      if (n % 200 == 0) begin
        af_thresh = CW'($urandom_range(0, 31));
        ae_thresh = CW'($urandom_range(0, 31));
      end
      wp = ((n / 300) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      cycle(($urandom_range(0, 255) == 0),
            ($urandom_range(0, 99) < wp),
            ($urandom_range(0, 99) < rp),
            DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Second-generation synchronous FIFO: single clock, parametrised width and depth (any DEPTH ≥ 2, not only powers of two), selectable standard or first-word-fall-through read mode.
Adds occupancy count, programmable almost-full/almost-empty thresholds, write-through-when-full on a simultaneous read, and overflow/underflow error pulses.
Drop-in buffer between producer/consumer stages that need watermark flow control.

Parameters:
DATA_WIDTH, 8, width of din/dout
DEPTH, 16, number of entries (≥ 2)
FWFT, 0, 0 = standard read (registered dout after pop); 1 = first-word-fall-through (head visible on dout)
CNT_W, $clog2(DEPTH+1), width of count and threshold ports (derived; do not override)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
rd_en  in  1  read request
din  in  DATA_WIDTH  write data
af_thresh  in  CNT_W  almost-full threshold
ae_thresh  in  CNT_W  almost-empty threshold
dout  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
count  out  CNT_W  current occupancy
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst high at posedge): wr_ptr = rd_ptr = 0, count = 0, dout = 0, overflow = underflow = 0. All requests in the reset cycle are ignored. Contents are discarded; storage is not cleared.
- Flags are pure functions of the registered count, so they are glitch-free. After reset: empty = 1, full = 0, almost_empty = 1. almost_full = 1 only if af_thresh == 0. Threshold changes take effect combinationally.
- rd_ok = rd_en && !empty.
- wr_ok = wr_en && (!full || rd_ok). A write while full is accepted when a read pops in the same cycle.
- Pointers advance modulo DEPTH: next = (ptr == DEPTH-1) ? 0 : ptr+1.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Simultaneous read and write:
  - When empty: the write is accepted, the read is rejected (underflow pulses), count becomes 1.
  - When full: both are accepted and count stays DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- FWFT = 0:
  - On a posedge with rd_ok, dout <= mem[rd_ptr]. dout is valid from that edge and holds until the next rd_ok.
  - Read latency is 1 clock.
- FWFT = 1:
  - dout = mem[rd_ptr] when !empty, and 0 when empty.
  - rd_ok acknowledges and removes the head. The next entry appears on dout after that edge.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
- overflow <= wr_en && !wr_ok; underflow <= rd_en && !rd_ok. Both are registered, asserted for exactly the cycle following the rejected request, and forced to 0 by reset.
- Rejected requests do not modify pointers, count, memory or dout.
- Thresholds above DEPTH are legal: almost_full never asserts, almost_empty always asserts.

Decomposition:
- fifo_pkg:
  - cnt_width(depth) function.
  - fifo_mode_e enum {FIFO_STD, FIFO_FWFT}, mapped to FWFT.
  - Shared with the SVA checker.
- Sub-module fifo_mem: 1W/1R register array, DATA_WIDTH×DEPTH.
  - Synchronous write.
  - Asynchronous read of address rd_ptr.
  - No reset.
- Control (pointers, count, flags, error pulses, dout register) lives in sync_fifo_prog.

Test Plan:
- Common setup: DATA_WIDTH = 8, DEPTH = 16.
- Reset/flags: assert rst 2 cycles, af_thresh = 12, ae_thresh = 2 → empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0, dout = 0.
- Fill/drain with wrap: write 0..15 → full at count 16, almost_full from count 12. Read 8, write 16..23, read 16 → data 8..23 in order (FWFT = 0: one-cycle latency). almost_empty reasserts at count 2.
- Over/underflow: 17th write while full with rd_en = 0 → overflow pulses 1 cycle, count stays 16, data unchanged. Read with empty = 1 → underflow pulses 1 cycle, dout holds its last value.
- Simultaneous read/write:
  - At empty: write 0xA5 → underflow = 1, count = 1.
  - At count 5: count stays 5, order is preserved.
  - At full: write 0x3C accepted, no overflow, count = 16, 0x3C is read last.
- FWFT = 1 instance: write 0x11 → dout = 0x11 the next cycle with no rd_en. Pop → dout = next word, or 0 once empty.
- Reset mid-operation: at count 9, assert rst together with wr_en and rd_en → next cycle count = 0, empty = 1, no overflow/underflow pulse. A subsequent write/read of 0x77 returns 0x77.
